// File: rtl/ifu_axi_ar_pkg.sv
// ----------------------------------------------------------------------------
// ifu_axi_ar_pkg
// Shared types and helpers for the IFU AXI read-address scheduler and the
// round-robin arbiter it uses.
//   state_e  : scheduler FSM states (IDLE, ISSUE)
//   OUT_W    : width of the in-flight AR counter
//   IDX_W    : width of a requester index (covers up to 8 requesters)
//   next_rr  : round-robin pointer advance with wrap at n
// ----------------------------------------------------------------------------
package ifu_axi_ar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int OUT_W = 4;
  localparam int IDX_W = 3;

  // Pointer one past ptr, wrapping to 0 once it reaches n.
  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] ptr,
                                               input int unsigned      n);
    logic [IDX_W:0] nxt;
    nxt = {1'b0, ptr} + (IDX_W+1)'(1);
    return (nxt >= (IDX_W+1)'(n)) ? '0 : nxt[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/ifu_axi_ar_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Picks the first set bit of req scanning
// ptr, ptr+1, ... modulo N. Shared by the AXI channel schedulers.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority position (must be < N)
//   grant out N      one-hot winner (all zero when req == 0)
//   idx   out IDX_W  encoded winner (0 when req == 0)
//   any   out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
  import ifu_axi_ar_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] sel;
  logic [IDX_W:0] sum;

  // NOTE: every signal driven here gets a value on every path before any
  // conditional update, so no latch can be inferred.
  always_comb begin
    // Rotate so that position ptr lands on bit 0, then take the lowest set bit.
    rot = N'({req, req} >> ptr);
    sel = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) sel = (IDX_W+1)'(j);
    end
    // Undo the rotation: winner = (ptr + sel) mod N.
    sum = sel + {1'b0, ptr};
    if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
    idx   = sum[IDX_W-1:0];
    any   = |req;
    grant = '0;
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/ifu_axi_ar_sched.sv
// ----------------------------------------------------------------------------
// ifu_axi_ar_sched
// Schedules IFU fetch read requests onto the single AXI AR channel.
// Round-robin between NUM_REQ requesters; the winner's address and index are
// registered and held on AR until arready. In-flight reads are limited by a
// credit counter that is released on R-channel last beats.
//
// Optional build macro IFU_AR_DEMAND_PRIO_EN:
//   requester 0 (demand fetch) always wins when valid and may use the last
//   credit; the other requesters round-robin among themselves and are held
//   back once only one credit remains.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/addr    per-requester request; addr slice i = requester i
//   req_grant         one-hot pulse on the AR handshake cycle
//   ifu_axi_ar*       AXI AR channel (arid = winner index, zero-extended)
//   ifu_axi_rvalid/rlast/rready  R channel observation, rready tied high
//   outstanding       in-flight AR count
//   busy              FSM not idle or reads still in flight
//   err_underflow     sticky: rlast seen with nothing outstanding
// ----------------------------------------------------------------------------
module ifu_axi_ar_sched
  import ifu_axi_ar_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int AW              = 32,
  parameter int IDW             = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic                  ifu_axi_arvalid,
  input  logic                  ifu_axi_arready,
  output logic [AW-1:0]         ifu_axi_araddr,
  output logic [IDW-1:0]        ifu_axi_arid,
  input  logic                  ifu_axi_rvalid,
  input  logic                  ifu_axi_rlast,
  output logic                  ifu_axi_rready,
  output logic [OUT_W-1:0]      outstanding,
  output logic                  busy,
  output logic                  err_underflow
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [NUM_REQ-1:0] win_oh_q;
  logic [AW-1:0]      araddr_q;
  logic [IDW-1:0]     arid_q;
  logic [OUT_W-1:0]   out_q;
  logic               err_q;

  logic               cred_ok;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_oh;

  logic               load;
  logic               ar_hs;
  logic               r_done;

  assign cred_ok = out_q < OUT_W'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef IFU_AR_DEMAND_PRIO_EN
  logic cred_rest_ok;
  logic demand;

  // Non-demand requesters keep one credit in reserve for demand fetch.
  assign cred_rest_ok = out_q < OUT_W'(MAX_OUTSTANDING - 1);
  assign demand       = req_valid[0] & cred_ok;

  always_comb begin
    arb_req = '0;
    if (cred_rest_ok) arb_req = req_valid & ~NUM_REQ'(1);
  end

  always_comb begin
    sel_valid = demand | arb_any;
    sel_idx   = demand ? '0 : arb_idx;
    sel_oh    = demand ? NUM_REQ'(1) : arb_grant;
  end
`else
  always_comb begin
    arb_req = '0;
    if (cred_ok) arb_req = req_valid;
  end

  always_comb begin
    sel_valid = arb_any;
    sel_idx   = arb_idx;
    sel_oh    = arb_grant;
  end
`endif

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ifu_axi_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_hs  = (state_q == ISSUE) & ifu_axi_arready;
  assign r_done = ifu_axi_rvalid & ifu_axi_rlast;

  // --------------------------------------------------------------------------
  // AR payload and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q <= '0;
      arid_q   <= '0;
      win_q    <= '0;
      win_oh_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      // Captured once in IDLE and held through ISSUE, so a requester that
      // drops its request after selection cannot disturb the AR payload.
      if (load) begin
        araddr_q <= req_addr[sel_idx*AW +: AW];
        arid_q   <= IDW'(sel_idx);
        win_q    <= sel_idx;
        win_oh_q <= sel_oh;
      end
`ifdef IFU_AR_DEMAND_PRIO_EN
      // Demand grants bypass round-robin and leave the pointer alone.
      if (ar_hs && (win_q != '0)) rr_ptr_q <= next_rr(win_q, NUM_REQ);
`else
      if (ar_hs) rr_ptr_q <= next_rr(win_q, NUM_REQ);
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Credit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      case ({ar_hs, r_done})
        2'b10: out_q <= out_q + OUT_W'(1);
        2'b01: begin
          if (out_q == '0) err_q <= 1'b1;
          else             out_q <= out_q - OUT_W'(1);
        end
        default: ;  // none, or issue and retire together: count unchanged
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ifu_axi_arvalid = (state_q == ISSUE);
  assign ifu_axi_araddr  = araddr_q;
  assign ifu_axi_arid    = arid_q;
  assign ifu_axi_rready  = 1'b1;
  assign req_grant       = ar_hs ? win_oh_q : '0;
  assign outstanding     = out_q;
  assign busy            = (state_q != IDLE) | (out_q != '0);
  assign err_underflow   = err_q;

endmodule

// File: doc/ifu_axi_ar_sched.md
Name: ifu_axi_ar_sched

Overview:
- Schedules IFU fetch read requests onto the single IFU AXI read-address (AR) channel inside swerv/ifu.
- Round-robin arbitration between NUM_REQ requesters (demand fetch, prefetch, ...).
- Holds AR stable until ifu_axi_arready; arid carries the requester index.
- Limits in-flight reads with a credit counter released on R-channel last beats.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- AW, 32, address width
- IDW, 3, arid width; must satisfy 2**IDW >= NUM_REQ
- MAX_OUTSTANDING, 4, max AR issued without matching rlast (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_addr  in  NUM_REQ*AW  per-requester address, slice i = requester i
- req_grant  out  NUM_REQ  one-hot pulse on the cycle the request's AR handshake completes
- ifu_axi_arvalid  out  1  AR valid
- ifu_axi_arready  in  1  AR ready
- ifu_axi_araddr  out  AW  AR address
- ifu_axi_arid  out  IDW  winner index, zero-extended
- ifu_axi_rvalid  in  1  R valid
- ifu_axi_rlast  in  1  R last beat
- ifu_axi_rready  out  1  constant 1
- outstanding  out  4  in-flight AR count
- busy  out  1  state != IDLE or outstanding != 0
- err_underflow  out  1  sticky; set on rlast with outstanding==0

Behaviour:
- Reset values: arvalid=0, araddr=0, arid=0, req_grant=0, outstanding=0, err_underflow=0, state=IDLE, rr_ptr=0.
- Sync reset applies at any time. AR is abandoned mid-handshake; arvalid is low the cycle after the reset edge.
- States:
  - IDLE: if any req_valid and outstanding < MAX_OUTSTANDING, choose the winner and register araddr/arid. Next state ISSUE.
  - ISSUE: arvalid=1 with araddr/arid held. On arready: req_grant[winner]=1 that cycle, rr_ptr <= winner+1 (wraps at NUM_REQ), next state IDLE. Otherwise stay.
- Arbitration: first requester with req_valid=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Requester contract:
  - hold req_valid and req_addr stable until grant;
  - may deassert the cycle after grant;
  - a request dropped while latched is still issued (AXI forbids retracting arvalid).
- Latency: request seen in IDLE produces arvalid next cycle. Max throughput is one AR per 2 cycles.
- Credits:
  - inc on arvalid&arready; dec on rvalid&rlast (rready=1);
  - simultaneous inc+dec leaves the count unchanged;
  - at MAX_OUTSTANDING, IDLE does not select, and a pending request waits;
  - dec at 0: count stays 0 and err_underflow is set; only rst clears it.
- No requests: remains IDLE, outputs idle, rr_ptr unchanged.

Optional Feature:
- Macro IFU_AR_DEMAND_PRIO_EN.
- Defined: requester 0 (demand fetch) wins whenever req_valid[0]=1, regardless of rr_ptr. Round-robin applies among the others. rr_ptr is not updated on requester-0 grants.
  - Credit reserve: requesters !=0 are blocked when outstanding >= MAX_OUTSTANDING-1. Requester 0 may use the last credit.
- Undefined: pure round-robin, no reserve.

Decomposition:
- Package ifu_axi_ar_pkg:
  - state enum {IDLE, ISSUE};
  - localparam OUT_W=4;
  - function next_rr(ptr, n).
- Sub-module rr_arbiter: inputs req vector and pointer; outputs one-hot grant and encoded index. Combinational, reused by other AXI channel schedulers.

Test Plan:
- NUM_REQ=2, arready=1: req_valid=2'b11 held → grants alternate. First grant requester 0 (arid=0), then 1, period 2 cycles; araddr matches the requester's slice.
- req_valid=2'b01, arready low 5 cycles → arvalid high, araddr/arid stable for all 5 cycles; grant exactly on the arready cycle.
- MAX_OUTSTANDING=2, no R traffic, 3 requests → 2 ARs issued, outstanding=2, third blocked. One rvalid&rlast → outstanding=1, third AR issued 2 cycles later.
- outstanding=1: AR handshake and rlast in the same cycle → outstanding stays 1. rlast at outstanding=0 → stays 0, err_underflow=1 until rst.
- rst asserted while ISSUE/arvalid=1 → next cycle arvalid=0, outstanding=0, state IDLE, rr_ptr=0.
- IFU_AR_DEMAND_PRIO_EN, MAX=4, outstanding=3: req_valid=2'b10 → no issue; req_valid=2'b11 → requester 0 issued, outstanding=4.
